regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, data width of each register.
REQ-002 SHALL provide parameter NREG, default 32, number of architectural registers; AW = clog2(NREG).
REQ-003 SHALL provide parameter NRD, default 2, number of read ports.
REQ-004 SHALL provide parameter NWR, default 2, number of write ports; a higher port index has higher priority.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates occur on the rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port flush  input  1  synchronous clear of all scoreboard busy bits.
REQ-008 SHALL have port rd_addr  input  NRD*AW  read address, one field per port.
REQ-009 SHALL have port rd_data  output  NRD*WIDTH  combinational read data, one field per port.
REQ-010 SHALL have port rd_busy  output  NRD  pending-producer flag per read port.
REQ-011 SHALL have port we  input  NWR  write enable per write port.
REQ-012 SHALL have port wa  input  NWR*AW  write address per write port.
REQ-013 SHALL have port wd  input  NWR*WIDTH  write data per write port.
REQ-014 SHALL have port iss_val  input  1  a producer wants to claim destination iss_reg.
REQ-015 SHALL have port iss_reg  input  AW  destination register being claimed.
REQ-016 SHALL have port iss_ok  output  1  the claim is accepted this cycle.
REQ-017 SHALL have port busy_vec  output  NREG  current scoreboard state, one bit per register.

Function
REQ-018 Register 0 SHALL read as 0, SHALL ignore writes, and SHALL never become busy.
REQ-019 Register storage SHALL update on the clk rising edge for every port with we=1 and wa!=0.
REQ-020 When several write ports target the same address in one cycle, the highest-index port SHALL win.
REQ-021 Reads SHALL be combinational with write-through bypass: if any port writes rd_addr this cycle, rd_data SHALL equal that cycle's winning wd; otherwise it SHALL equal the stored value.
REQ-022 A write with we=1 to register r SHALL clear busy[r] at the next edge.
REQ-023 iss_ok SHALL be 1 when iss_reg==0, when busy[iss_reg]==0, or when a write port clears iss_reg this cycle; otherwise iss_ok SHALL be 0.
REQ-024 When iss_val=1, iss_ok=1, iss_reg!=0 and flush=0, busy[iss_reg] SHALL be 1 at the next edge.
REQ-025 When a claim and a clearing write hit the same register in one cycle, the claim SHALL win and busy SHALL be 1.
REQ-026 When flush=1, all busy bits SHALL be 0 at the next edge; flush SHALL override any claim; writes during flush SHALL still update storage.
REQ-027 rd_busy[i] SHALL equal busy[rd_addr[i]] AND NOT (a write to rd_addr[i] this cycle); rd_busy[i] SHALL be 0 for address 0.
REQ-028 Latency: a write or claim SHALL be visible in storage and busy_vec one cycle after its edge; bypass SHALL make write data visible in the same cycle.
REQ-029 Addresses >= NREG SHALL read as 0, SHALL be ignored on write, and SHALL give iss_ok=0.

Reset
REQ-030 Asserting reset SHALL immediately clear all registers and all busy bits, independent of clk.
REQ-031 While reset is asserted, rd_data SHALL be 0 on every port, busy_vec SHALL be 0, rd_busy SHALL be 0, and iss_ok SHALL be 1.
REQ-032 Reset asserted mid-claim or mid-write SHALL discard that claim or write; no state change SHALL occur on an edge while reset=1.

Verification
REQ-033 Write r5=0xDEADBEEF on port 0 while rd_addr0=5 -> rd_data0=0xDEADBEEF in the same cycle and on all later cycles.
REQ-034 Same cycle: port0 writes r7=0x1, port1 writes r7=0x2 -> bypass and stored value are both 0x2.
REQ-035 Claim r3 (iss_ok=1) -> busy_vec[3]=1 next cycle; second claim of r3 -> iss_ok=0; write r3 -> iss_ok=1 in that same cycle; next cycle busy_vec[3]=0.
REQ-036 Claim r4 together with a write to r4 -> busy_vec[4]=1 next cycle and stored r4 = written data.
REQ-037 Set busy on r1, r2, r9, then assert flush with iss_val=1, iss_reg=10 -> busy_vec=0 next cycle; claim of r10 dropped.
REQ-038 Write r0=0xFFFFFFFF and claim r0 -> rd_data for r0 = 0 and busy_vec[0]=0; assert reset asynchronously between edges -> all outputs at reset values before the next edge.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with an integrated busy scoreboard.
//
//   clk       rising-edge clock for all state
//   reset     asynchronous active-high clear of storage and scoreboard
//   flush     synchronous clear of every busy bit (storage writes still land)
//   rd_addr   NRD packed read addresses, AW bits each
//   rd_data   NRD packed combinational read results (write-through bypass)
//   rd_busy   per read port: addressed register has a pending producer
//   we/wa/wd  NWR write ports; the highest index wins on address collision
//   iss_val   a producer requests to claim destination iss_reg
//   iss_reg   destination being claimed
//   iss_ok    claim can be accepted this cycle
//   busy_vec  scoreboard state, one bit per register
//
// Register 0 is hardwired to zero and never becomes busy. Addresses at or
// beyond NREG read as zero, ignore writes and refuse claims.
module regfile_sb #(
  parameter int WIDTH = 32,
  parameter int NREG  = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  parameter int AW    = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*WIDTH-1:0]  rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*AW-1:0]     wa,
  input  logic [NWR*WIDTH-1:0]  wd,
  input  logic                  iss_val,
  input  logic [AW-1:0]         iss_reg,
  output logic                  iss_ok,
  output logic [NREG-1:0]       busy_vec
);

  logic [WIDTH-1:0] regs [NREG];
  logic [NREG-1:0]  busy;
  logic [NREG-1:0]  busy_nxt;

  // Unpacked views of the packed port buses.
  logic [AW-1:0]    wa_f [NWR];
  logic [WIDTH-1:0] wd_f [NWR];
  logic [AW-1:0]    ra_f [NRD];
  logic [NWR-1:0]   wr_ok;

  // Per-register resolved write for this cycle.
  logic [NREG-1:0]  wr_hit;
  logic [WIDTH-1:0] wr_val [NREG];

  logic             iss_ok_raw;
  logic             claim_set;

  // Nonzero and inside the implemented register range.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && (32'(a) < NREG);
  endfunction

  function automatic logic addr_in_range(input logic [AW-1:0] a);
    return 32'(a) < NREG;
  endfunction

  always_comb begin
    for (int unsigned j = 0; j < NWR; j++) begin
      wa_f[j]  = wa[j*AW +: AW];
      wd_f[j]  = wd[j*WIDTH +: WIDTH];
      wr_ok[j] = we[j] && addr_ok(wa_f[j]);
    end
    for (int unsigned i = 0; i < NRD; i++) begin
      ra_f[i] = rd_addr[i*AW +: AW];
    end
  end

  // Later ports overwrite earlier ones, giving the highest index priority.
  always_comb begin
    wr_hit = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      wr_val[r] = '0;
    end
    for (int unsigned r = 1; r < NREG; r++) begin
      for (int unsigned j = 0; j < NWR; j++) begin
        if (wr_ok[j] && (wa_f[j] == AW'(r))) begin
          wr_hit[r] = 1'b1;
          wr_val[r] = wd_f[j];
        end
      end
    end
  end

  // A busy destination may still be claimed if a write retires it this cycle.
  always_comb begin
    iss_ok_raw = 1'b0;
    if (!addr_in_range(iss_reg)) begin
      iss_ok_raw = 1'b0;
    end else if (iss_reg == '0) begin
      iss_ok_raw = 1'b1;
    end else begin
      iss_ok_raw = !busy[iss_reg] || wr_hit[iss_reg];
    end
  end

  assign iss_ok    = reset ? 1'b1 : iss_ok_raw;
  assign claim_set = iss_val && iss_ok_raw && addr_ok(iss_reg) && !flush;

  // Clear on write first, then set on claim, so a same-cycle claim wins.
  always_comb begin
    busy_nxt = busy & ~wr_hit;
    if (claim_set) begin
      busy_nxt[iss_reg] = 1'b1;
    end
    if (flush) begin
      busy_nxt = '0;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        regs[r] <= '0;
      end
      busy <= '0;
    end else begin
      for (int unsigned r = 1; r < NREG; r++) begin
        if (wr_hit[r]) begin
          regs[r] <= wr_val[r];
        end
      end
      busy <= busy_nxt;
    end
  end

  // Outputs are forced to reset values while reset is held, even though a
  // bypassed write would otherwise be visible.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      if (!reset && addr_ok(ra_f[i])) begin
        if (wr_hit[ra_f[i]]) begin
          rd_data[i*WIDTH +: WIDTH] = wr_val[ra_f[i]];
          rd_busy[i]                = 1'b0;
        end else begin
          rd_data[i*WIDTH +: WIDTH] = regs[ra_f[i]];
          rd_busy[i]                = busy[ra_f[i]];
        end
      end
    end
  end

  assign busy_vec = busy;

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  we;
  logic [9:0]  wa;
  logic [63:0] wd;
  logic        iss_val;
  logic [4:0]  iss_reg;
  logic        iss_ok;
  logic [31:0] busy_vec;

  int checks = 0;
  int failures = 0;

  regfile_sb #(.WIDTH(32), .NREG(32), .NRD(2), .NWR(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .we(we), .wa(wa), .wd(wd),
    .iss_val(iss_val), .iss_reg(iss_reg), .iss_ok(iss_ok),
    .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic idle();
    flush = 1'b0; we = '0; wa = '0; wd = '0; iss_val = 1'b0; iss_reg = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle(); rd_addr = {5'd0, 5'd5};
    we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'h0, 32'hDEADBEEF};
    #1;
    checks++; if (rd_data !== 64'h0) begin failures++; $display("FAIL rst_rd_data got=%h exp=%h", rd_data, 64'h0); end
    checks++; if (busy_vec !== 32'h0) begin failures++; $display("FAIL rst_busy_vec got=%h exp=%h", busy_vec, 32'h0); end
    checks++; if (rd_busy !== 2'b00) begin failures++; $display("FAIL rst_rd_busy got=%b exp=%b", rd_busy, 2'b00); end
    checks++; if (iss_ok !== 1'b1) begin failures++; $display("FAIL rst_iss_ok got=%b exp=%b", iss_ok, 1'b1); end
    @(posedge clk); #1;
    @(negedge clk); reset = 1'b0; idle(); #1;
    checks++; if (rd_data[31:0] !== 32'h0) begin failures++; $display("FAIL rst_write_discard got=%h exp=%h", rd_data[31:0], 32'h0); end
  endtask

  task automatic test_write_bypass();
    @(negedge clk); idle(); rd_addr = {5'd0, 5'd5};
    we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'h0, 32'hDEADBEEF}; #1;
    checks++; if (rd_data[31:0] !== 32'hDEADBEEF) begin failures++; $display("FAIL bypass_r5 got=%h exp=%h", rd_data[31:0], 32'hDEADBEEF); end
    @(negedge clk); idle(); #1;
    checks++; if (rd_data[31:0] !== 32'hDEADBEEF) begin failures++; $display("FAIL stored_r5 got=%h exp=%h", rd_data[31:0], 32'hDEADBEEF); end
    @(negedge clk); #1;
    checks++; if (rd_data[31:0] !== 32'hDEADBEEF) begin failures++; $display("FAIL stored_r5_later got=%h exp=%h", rd_data[31:0], 32'hDEADBEEF); end
  endtask

  task automatic test_write_priority();
    @(negedge clk); idle(); rd_addr = {5'd7, 5'd0};
    we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'h2, 32'h1}; #1;
    checks++; if (rd_data[63:32] !== 32'h2) begin failures++; $display("FAIL prio_bypass got=%h exp=%h", rd_data[63:32], 32'h2); end
    @(negedge clk); idle(); #1;
    checks++; if (rd_data[63:32] !== 32'h2) begin failures++; $display("FAIL prio_stored got=%h exp=%h", rd_data[63:32], 32'h2); end
  endtask

  task automatic test_high_reg();
    @(negedge clk); idle(); rd_addr = {5'd31, 5'd0};
    we = 2'b10; wa = {5'd31, 5'd0}; wd = {32'hA5A5_0031, 32'h0};
    @(negedge clk); idle(); #1;
    checks++; if (rd_data[63:32] !== 32'hA5A5_0031) begin failures++; $display("FAIL r31_stored got=%h exp=%h", rd_data[63:32], 32'hA5A5_0031); end
  endtask

  task automatic test_claim();
    @(negedge clk); idle(); rd_addr = {5'd0, 5'd3};
    iss_val = 1'b1; iss_reg = 5'd3; #1;
    checks++; if (iss_ok !== 1'b1) begin failures++; $display("FAIL claim_r3_ok got=%b exp=%b", iss_ok, 1'b1); end
    @(posedge clk); #1;
    checks++; if (busy_vec !== 32'h8) begin failures++; $display("FAIL claim_r3_busy got=%h exp=%h", busy_vec, 32'h8); end
    @(negedge clk); iss_val = 1'b1; iss_reg = 5'd3; #1;
    checks++; if (iss_ok !== 1'b0) begin failures++; $display("FAIL reclaim_r3_ok got=%b exp=%b", iss_ok, 1'b0); end
    checks++; if (rd_busy !== 2'b01) begin failures++; $display("FAIL rd_busy_r3 got=%b exp=%b", rd_busy, 2'b01); end
    @(negedge clk); idle(); iss_reg = 5'd3;
    we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'h0, 32'h33}; #1;
    checks++; if (iss_ok !== 1'b1) begin failures++; $display("FAIL retire_r3_ok got=%b exp=%b", iss_ok, 1'b1); end
    checks++; if (rd_busy !== 2'b00) begin failures++; $display("FAIL retire_r3_rd_busy got=%b exp=%b", rd_busy, 2'b00); end
    @(posedge clk); #1;
    checks++; if (busy_vec !== 32'h0) begin failures++; $display("FAIL retire_r3_busy got=%h exp=%h", busy_vec, 32'h0); end
  endtask

  task automatic test_claim_write_same();
    @(negedge clk); idle(); rd_addr = {5'd0, 5'd4};
    iss_val = 1'b1; iss_reg = 5'd4;
    we = 2'b01; wa = {5'd0, 5'd4}; wd = {32'h0, 32'h44}; #1;
    checks++; if (iss_ok !== 1'b1) begin failures++; $display("FAIL cw_r4_ok got=%b exp=%b", iss_ok, 1'b1); end
    @(negedge clk); idle(); #1;
    checks++; if (busy_vec !== 32'h10) begin failures++; $display("FAIL cw_r4_busy got=%h exp=%h", busy_vec, 32'h10); end
    checks++; if (rd_data[31:0] !== 32'h44) begin failures++; $display("FAIL cw_r4_data got=%h exp=%h", rd_data[31:0], 32'h44); end
    checks++; if (rd_busy !== 2'b01) begin failures++; $display("FAIL cw_r4_rd_busy got=%b exp=%b", rd_busy, 2'b01); end
  endtask

  task automatic test_flush();
    logic [4:0] regs_to_claim [3] = '{5'd1, 5'd2, 5'd9};
    foreach (regs_to_claim[k]) begin
      @(negedge clk); idle(); iss_val = 1'b1; iss_reg = regs_to_claim[k];
    end
    @(negedge clk); idle(); #1;
    checks++; if (busy_vec !== 32'h216) begin failures++; $display("FAIL pre_flush_busy got=%h exp=%h", busy_vec, 32'h216); end
    @(negedge clk); flush = 1'b1; iss_val = 1'b1; iss_reg = 5'd10; rd_addr = {5'd0, 5'd12};
    we = 2'b01; wa = {5'd0, 5'd12}; wd = {32'h0, 32'h1234};
    @(negedge clk); idle(); #1;
    checks++; if (busy_vec !== 32'h0) begin failures++; $display("FAIL flush_busy got=%h exp=%h", busy_vec, 32'h0); end
    checks++; if (rd_data[31:0] !== 32'h1234) begin failures++; $display("FAIL flush_write got=%h exp=%h", rd_data[31:0], 32'h1234); end
  endtask

  task automatic test_reg0();
    @(negedge clk); idle(); rd_addr = {5'd0, 5'd0};
    we = 2'b01; wa = {5'd0, 5'd0}; wd = {32'h0, 32'hFFFFFFFF};
    iss_val = 1'b1; iss_reg = 5'd0; #1;
    checks++; if (rd_data[31:0] !== 32'h0) begin failures++; $display("FAIL r0_bypass got=%h exp=%h", rd_data[31:0], 32'h0); end
    checks++; if (iss_ok !== 1'b1) begin failures++; $display("FAIL r0_iss_ok got=%b exp=%b", iss_ok, 1'b1); end
    @(negedge clk); idle(); #1;
    checks++; if (busy_vec !== 32'h0) begin failures++; $display("FAIL r0_busy got=%h exp=%h", busy_vec, 32'h0); end
    checks++; if (rd_data[31:0] !== 32'h0) begin failures++; $display("FAIL r0_stored got=%h exp=%h", rd_data[31:0], 32'h0); end
  endtask

  task automatic test_async_reset();
    @(negedge clk); idle(); rd_addr = {5'd6, 5'd8};
    we = 2'b01; wa = {5'd0, 5'd6}; wd = {32'h0, 32'h66}; iss_val = 1'b1; iss_reg = 5'd6;
    @(negedge clk); idle();
    we = 2'b01; wa = {5'd0, 5'd8}; wd = {32'h0, 32'h88}; iss_val = 1'b1; iss_reg = 5'd8; #1;
    checks++; if (rd_data !== {32'h66, 32'h88}) begin failures++; $display("FAIL pre_reset_rd got=%h exp=%h", rd_data, {32'h66, 32'h88}); end
    checks++; if (busy_vec !== 32'h40) begin failures++; $display("FAIL pre_reset_busy got=%h exp=%h", busy_vec, 32'h40); end
    #1 reset = 1'b1; #1;
    checks++; if (rd_data !== 64'h0) begin failures++; $display("FAIL async_rd_data got=%h exp=%h", rd_data, 64'h0); end
    checks++; if (busy_vec !== 32'h0) begin failures++; $display("FAIL async_busy got=%h exp=%h", busy_vec, 32'h0); end
    checks++; if (rd_busy !== 2'b00) begin failures++; $display("FAIL async_rd_busy got=%b exp=%b", rd_busy, 2'b00); end
    checks++; if (iss_ok !== 1'b1) begin failures++; $display("FAIL async_iss_ok got=%b exp=%b", iss_ok, 1'b1); end
    @(posedge clk); #1;
    @(negedge clk); reset = 1'b0; idle(); #1;
    checks++; if (rd_data !== 64'h0) begin failures++; $display("FAIL post_reset_rd got=%h exp=%h", rd_data, 64'h0); end
    checks++; if (busy_vec !== 32'h0) begin failures++; $display("FAIL post_reset_busy got=%h exp=%h", busy_vec, 32'h0); end
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_write_priority();
    test_high_reg();
    test_claim();
    test_claim_write_same();
    test_flush();
    test_reg0();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
